fifo_rr_arbiter: RTL and testbench
==================================

# fifo_rr_arbiter

Round-robin arbiter that drains N input FIFOs (one per virtual channel) into a single shared output FIFO, one word per cycle. It sits between the per-channel input FIFOs and the merged downstream FIFO. It also performs the flow control the downstream path needs: it pauses on almost-full and latches a sticky error on overflow.

## Interface
Parameters:
- N_REQ, 4, number of requesting input FIFOs (≥2)
- DATA_W, 8, word width
- IDX_W, $clog2(N_REQ), width of grant index
- CNT_W, 16, width of push counter

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset rst, synchronous, active-high; clock clk
- enable  in  1  arbitration allowed; 0 drains nothing new
- req_empty  in  N_REQ  empty flag of input FIFO i at bit i
- req_data  in  N_REQ*DATA_W  read data of FIFO i at [i*DATA_W +: DATA_W], valid the cycle after its pop
- req_pop  out  N_REQ  one-hot (or zero) pop strobe, combinational
- out_almost_full  in  1  downstream FIFO has ≤1 free entry
- out_full  in  1  downstream FIFO full
- out_push  out  1  push strobe to downstream FIFO, registered
- out_data  out  DATA_W  req_data slice selected by grant_id, combinational
- grant_id  out  IDX_W  index of last popped FIFO, registered
- state  out  2  IDLE=0, ACTIVE=1, PAUSE=2, ERROR=3
- error_full  out  1  sticky overflow flag
- push_count  out  CNT_W  words pushed since reset, wraps modulo 2^CNT_W

## Operation
- any_req = |(~req_empty); go = enable & any_req.
- Pop condition: state==ACTIVE & go & !out_almost_full & !out_full & !rst.
- When the pop condition holds, req_pop has exactly one bit set: the first non-empty index searched from rr_ptr+1 upward, modulo N_REQ. Otherwise req_pop is 0.
- On a pop: rr_ptr and grant_id load the granted index. The next cycle has out_push=1, and out_data = req_data slice[grant_id].
- push_count increments on every cycle with out_push=1.
- State transitions, evaluated each cycle with priority top to bottom:
  - any state, out_push & out_full → ERROR
  - IDLE: go & !out_almost_full → ACTIVE; else stay
  - ACTIVE: out_almost_full → PAUSE; else !go → IDLE; else stay
  - PAUSE: !out_almost_full → ACTIVE if go, else IDLE; else stay
  - ERROR: stays until rst. req_pop=0, error_full=1.
- No pops are issued in IDLE, PAUSE or ERROR.
- A push already in flight (pop issued the previous cycle) always completes, including on entry to PAUSE or IDLE.

## Timing
- Reset values: state=IDLE, rr_ptr=N_REQ-1 (first search starts at 0), grant_id=0, out_push=0, error_full=0, push_count=0. req_pop=0 while rst=1.
- Latency:
  - IDLE→ACTIVE costs 1 cycle with no pop.
  - Pop at cycle t → out_push at t+1.
  - Sustained throughput is 1 word/cycle while ACTIVE.
- Fairness: with all FIFOs non-empty, grants rotate 0,1,2,3,0… Each requester waits at most N_REQ-1 grants.
- Boundaries:
  - Input FIFO going empty: takes effect the same cycle, because the decision is combinational on req_empty.
  - Only one non-empty FIFO: it is granted every cycle.
  - out_almost_full rising with a pop in flight: that push completes. This is legal because almost_full guarantees one free entry.
  - out_full together with out_push: the push still reaches the FIFO pins, and error_full sets the next cycle.
  - enable falling mid-stream: no new pop, and the in-flight push completes.
  - rst mid-operation: a push that would occur in the rst cycle is suppressed (out_push=0), and that word is lost.

## Structure
- Package flow_ctrl_pkg holds:
  - state encodings ST_IDLE, ST_ACTIVE, ST_PAUSE, ST_ERROR
  - state width constant 2
  - default DATA_W
- Sub-module rr_priority_encoder (N_REQ, combinational):
  - inputs: request vector, rr_ptr
  - outputs: one-hot grant, grant index, valid
- Top module holds the FSM, rr_ptr, grant_id, out_push, error_full and push_count registers, plus the output mux.

## Test plan
- Reset then enable=1, req_empty=4'b0000, out_almost_full=0: req_pop sequence 0001,0010,0100,1000,0001 from the second cycle after enable. out_push follows one cycle later with matching out_data. push_count=5 after 5 pushes.
- req_empty=4'b1011 (only FIFO 2 has data): req_pop=0100 every ACTIVE cycle and grant_id=2. When req_empty goes to 4'b1111, req_pop=0 the same cycle and state=IDLE the next cycle.
- out_almost_full=1 mid-stream: the in-flight push completes, state=PAUSE, req_pop=0. When out_almost_full returns to 0, state=ACTIVE and popping resumes at rr_ptr+1.
- Force out_full=1 while out_push=1: error_full=1 and state=ERROR next cycle. req_pop stays 0 despite non-empty inputs until rst, after which all reset values are restored.
- Assert rst one cycle after a pop: out_push=0 in the rst cycle, push_count unchanged (0 after reset). The first grant after reset is FIFO 0.

Source files
------------

// File: rtl/flow_ctrl_pkg.sv
// Shared encodings and defaults for the downstream flow-control arbiter.
package flow_ctrl_pkg;
  localparam int STATE_W        = 2;
  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_PAUSE  = 2'd2,
    ST_ERROR  = 2'd3
  } state_t;
endpackage

// File: rtl/rr_priority_encoder.sv
// Round-robin priority encoder: first set request strictly after rr_ptr, wrapping.
module rr_priority_encoder #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             valid
);

  logic [IDX_W-1:0] pos;

  // Scan from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    pos       = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      pos = IDX_W'((int'(rr_ptr) + k) % N_REQ);
      if (req[pos]) begin
        grant     = N_REQ'(1) << pos;
        grant_idx = pos;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Drains N input FIFOs round-robin into one downstream FIFO, one word per cycle,
// pausing on almost-full and latching a sticky error on overflow.
module fifo_rr_arbiter
  import flow_ctrl_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int IDX_W  = $clog2(N_REQ),
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [N_REQ-1:0]        req_empty,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_pop,
  input  logic                    out_almost_full,
  input  logic                    out_full,
  output logic                    out_push,
  output logic [DATA_W-1:0]       out_data,
  output logic [IDX_W-1:0]        grant_id,
  output logic [STATE_W-1:0]      state,
  output logic                    error_full,
  output logic [CNT_W-1:0]        push_count
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, grant_id_q, enc_idx;
  logic [N_REQ-1:0] enc_grant;
  logic             enc_valid, push_q, error_q, any_req, go, pop_fire;
  logic [CNT_W-1:0] count_q;

  assign any_req  = |(~req_empty);
  assign go       = enable & any_req;
  assign pop_fire = (state_q == ST_ACTIVE) & go & ~out_almost_full & ~out_full & ~rst & enc_valid;

  rr_priority_encoder #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_enc (
    .req       (~req_empty),
    .rr_ptr    (rr_ptr_q),
    .grant     (enc_grant),
    .grant_idx (enc_idx),
    .valid     (enc_valid)
  );

  assign req_pop = pop_fire ? enc_grant : '0;
  // A word in flight during the reset cycle is dropped rather than pushed.
  assign out_push   = push_q & ~rst;
  assign grant_id   = grant_id_q;
  assign state      = state_q;
  assign error_full = error_q;
  assign push_count = count_q;

  always_comb begin
    out_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id_q == IDX_W'(i)) out_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d = state_q;
    if (out_push && out_full) begin
      state_d = ST_ERROR;
    end else begin
      case (state_q)
        ST_IDLE:   if (go && !out_almost_full) state_d = ST_ACTIVE;
        ST_ACTIVE: begin
          if (out_almost_full) state_d = ST_PAUSE;
          else if (!go)        state_d = ST_IDLE;
        end
        ST_PAUSE:  if (!out_almost_full) state_d = go ? ST_ACTIVE : ST_IDLE;
        ST_ERROR:  state_d = ST_ERROR;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= IDX_W'(N_REQ - 1);
      grant_id_q <= '0;
      push_q     <= 1'b0;
      error_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q <= state_d;
      push_q  <= pop_fire;
      if (pop_fire) begin
        rr_ptr_q   <= enc_idx;
        grant_id_q <= enc_idx;
      end
      if (out_push) count_q <= count_q + CNT_W'(1);
      if (out_push && out_full) error_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Randomized scoreboard bench for fifo_rr_arbiter against a queue-based reference model.
module tb_fifo_rr_arbiter;
  localparam int N = 4, DW = 8, IW = 2, CW = 16, DEPTH = 6;

  logic            clk = 1'b0;
  logic            rst, enable, out_almost_full, out_full;
  logic [N-1:0]    req_empty, req_pop;
  logic [N*DW-1:0] req_data;
  logic            out_push, error_full;
  logic [DW-1:0]   out_data;
  logic [IW-1:0]   grant_id;
  logic [1:0]      state;
  logic [CW-1:0]   push_count;

  fifo_rr_arbiter #(.N_REQ(N), .DATA_W(DW), .IDX_W(IW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .req_empty(req_empty), .req_data(req_data),
    .req_pop(req_pop), .out_almost_full(out_almost_full), .out_full(out_full),
    .out_push(out_push), .out_data(out_data), .grant_id(grant_id), .state(state),
    .error_full(error_full), .push_count(push_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] src_q[N][$];
  int         n_checks = 0, n_fail = 0, push_seen = 0;
  bit         chk_on = 0, exp_push_now = 0;

  // reference model: state number, last granted FIFO, pending push, counters
  int m_state = 0, m_last = N - 1, m_gid = 0, m_cnt = 0;
  bit m_pend = 0, m_err = 0;
  int last_pidx = -1;
  int dcount = 0;
  bit force_full_mode = 0;
  int mask_mode = 0, drain_pct = 100, en_pct = 100, refill_pct = 100;
  logic [N-1:0] fixed_mask = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every DUT push must match the oldest outstanding expected word
  always @(negedge clk) begin
    #2;
    if (chk_on) begin
      check("out_push", out_push, exp_push_now);
      if (out_push) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_push: got out_data %0h expected no push", out_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_data", out_data, e.data);
          check("grant_id_at_push", grant_id, e.idx);
          push_seen++;
        end
      end
    end
  end

  task automatic step(input bit do_rst);
    logic [N-1:0] mask, exp_pop;
    bit go, push_now, pop_ok, afull;
    int pidx;
    @(negedge clk);
    if (dcount > 0 && $urandom_range(0, 99) < drain_pct) dcount--;
    for (int i = 0; i < N; i++)
      if (src_q[i].size() < 6 && $urandom_range(0, 99) < refill_pct) src_q[i].push_back(8'($urandom));
    rst    = do_rst;
    enable = ($urandom_range(0, 99) < en_pct);
    case (mask_mode)
      1:       for (int i = 0; i < N; i++) mask[i] = ($urandom_range(0, 3) == 0);
      2:       mask = fixed_mask;
      default: mask = '0;
    endcase
    for (int i = 0; i < N; i++) req_empty[i] = (src_q[i].size() == 0) | mask[i];
    if (force_full_mode) begin
      out_full        = m_pend;
      out_almost_full = m_pend;
    end else begin
      out_almost_full = (dcount >= DEPTH - 1);
      out_full        = (dcount >= DEPTH);
    end
    #1;
    if (chk_on) begin
      check("state", state, m_state);
      check("error_full", error_full, m_err);
      check("push_count", push_count, m_cnt);
      check("grant_id", grant_id, m_gid);
    end
    afull    = out_almost_full;
    go       = enable && (req_empty != {N{1'b1}});
    push_now = m_pend && !rst;
    exp_push_now = push_now;
    pop_ok   = !rst && m_state == 1 && go && !afull && !out_full;
    exp_pop  = '0;
    pidx     = -1;
    if (pop_ok) begin
      exp_t e;
      for (int k = 1; k <= N; k++) begin
        if (pidx < 0 && !req_empty[(m_last + k) % N]) pidx = (m_last + k) % N;
      end
      exp_pop[pidx] = 1'b1;
      e.idx  = pidx;
      e.data = src_q[pidx][0];
      sb.push_back(e);
    end
    if (chk_on) check("req_pop", req_pop, exp_pop);
    if (rst) begin
      m_state = 0; m_last = N - 1; m_gid = 0; m_cnt = 0; m_pend = 0; m_err = 0;
      sb.delete();
    end else begin
      if (push_now) m_cnt = (m_cnt + 1) % (1 << CW);
      if (push_now && out_full) begin
        m_state = 3;
        m_err   = 1;
      end else begin
        case (m_state)
          0: if (go && !afull) m_state = 1;
          1: if (afull) m_state = 2; else if (!go) m_state = 0;
          2: if (!afull) m_state = go ? 1 : 0;
          default: m_state = 3;
        endcase
      end
      m_pend = pop_ok;
      if (pop_ok) begin
        m_last = pidx;
        m_gid  = pidx;
      end
    end
    last_pidx = pidx;
    @(posedge clk);
    if (last_pidx >= 0) req_data[last_pidx*DW +: DW] = src_q[last_pidx].pop_front();
    if (push_now && dcount < DEPTH) dcount++;
    chk_on = 1;
  endtask

  initial begin
    rst = 1; enable = 0; req_empty = '1; req_data = '0; out_almost_full = 0; out_full = 0;
    step(1); step(1); step(1);
    // all FIFOs non-empty, downstream never backs up: pure rotation
    for (int c = 0; c < 30; c++) step(0);
    // only FIFO 2 has data, then every FIFO runs dry
    mask_mode = 2; fixed_mask = 4'b1011;
    for (int c = 0; c < 15; c++) step(0);
    fixed_mask = 4'b1111;
    for (int c = 0; c < 4; c++) step(0);
    // random traffic with back-pressure and a mid-stream reset
    mask_mode = 1; en_pct = 85; refill_pct = 50; drain_pct = 40;
    for (int c = 0; c < 300; c++) step(c == 150);
    drain_pct = 25;
    for (int c = 0; c < 200; c++) step(0);
    // overflow: downstream reports full exactly while a push is in flight
    mask_mode = 0; en_pct = 100; refill_pct = 100; drain_pct = 100; force_full_mode = 1;
    for (int c = 0; c < 20; c++) step(0);
    check("error_state_reached", state, 3);
    check("error_flag_reached", error_full, 1);
    force_full_mode = 0; dcount = 0;
    step(1); step(1);
    mask_mode = 1; en_pct = 90; refill_pct = 60; drain_pct = 50;
    for (int c = 0; c < 200; c++) step(0);
    check("pushes_observed", push_seen > 100, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
